// File: rtl/sha_msg_padder_if.sv
// Block-formatter bus: 32-bit message word stream in, 512-bit padded block out.
//
// Handshake rules for both channels (valid/ready):
//   - a transfer happens on the rising edge where valid && ready are both high;
//   - while valid is high and ready is low the sender holds payload and flags stable;
//   - ready never depends combinationally on valid of the same channel.
// The word channel is i_valid/o_ready. The block channel is o_blk_valid/i_blk_ready.
interface sha_msg_padder_if #(
    parameter int MSG_SIZ = 512,
    parameter int MSG_BLK = 32
);
    logic               i_valid;
    logic               o_ready;
    logic [MSG_BLK-1:0] i_data;
    logic [2:0]         i_nbytes;
    logic               i_last;
    logic [MSG_SIZ-1:0] o_blk;
    logic               o_blk_valid;
    logic               i_blk_ready;
    logic               o_blk_first;
    logic               o_blk_last;

    // Message source / block sink side.
    modport master (
        output i_valid, i_data, i_nbytes, i_last, i_blk_ready,
        input  o_ready, o_blk, o_blk_valid, o_blk_first, o_blk_last
    );

    // Padder side.
    modport slave (
        input  i_valid, i_data, i_nbytes, i_last, i_blk_ready,
        output o_ready, o_blk, o_blk_valid, o_blk_first, o_blk_last
    );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs big-endian 32-bit words into 16-word blocks,
// appends the 0x80 marker, zero fill and the 64-bit message bit length, and
// hands complete blocks to the hash datapath with first/last block flags.
module sha_msg_padder #(
    parameter int MSG_SIZ = 512,
    parameter int MSG_BLK = 32,
    parameter int LEN_W   = 64
) (
    input  logic             clk,
    input  logic             reset,
    sha_msg_padder_if.slave  bus,
    output logic [1:0]       fsm_state
);
    localparam int WORDS = MSG_SIZ / MSG_BLK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [MSG_BLK-1:0] blk_buf [WORDS];
    logic [3:0]         idx;
    logic [LEN_W-1:0]   len;

    // in_msg: a message is open. msg_done: its last word has been taken.
    // mark_done: 0x80 is in place. first_pend: next emitted block is the first.
    // len_ok: the length may go in words 14/15 of the block being built
    // (marker sits at word <= 13 here, or in an earlier block).
    // hi_done / len_placed: length high / low words written.
    logic in_msg;
    logic msg_done;
    logic mark_done;
    logic first_pend;
    logic len_ok;
    logic hi_done;
    logic len_placed;

    logic               accept;
    logic               take;
    logic [MSG_BLK-1:0] marked_word;
    logic [MSG_BLK-1:0] pad_word;
    logic [MSG_BLK-1:0] wr_data;
    logic [LEN_W-1:0]   len_add;

    assign accept  = bus.i_valid && bus.o_ready;
    // Zero-byte words that are not last are consumed without touching storage.
    assign take    = accept && (bus.i_last || (bus.i_nbytes != 3'd0));
    assign len_add = LEN_W'({bus.i_nbytes, 3'b000});

    // Final partial word: keep the valid leading bytes, place 0x80 right after them.
    always_comb begin
        marked_word = 32'h8000_0000;
        case (bus.i_nbytes)
            3'd1:    marked_word = {bus.i_data[31:24], 24'h80_0000};
            3'd2:    marked_word = {bus.i_data[31:16], 16'h8000};
            3'd3:    marked_word = {bus.i_data[31:8], 8'h80};
            default: marked_word = 32'h8000_0000;
        endcase
    end

    // Padding word for the current PAD slot: marker first, then length words, else zero.
    always_comb begin
        pad_word = '0;
        if (!mark_done) begin
            pad_word = 32'h8000_0000;
        end else if ((idx == 4'd14) && len_ok) begin
            pad_word = len[63:32];
        end else if ((idx == 4'd15) && hi_done) begin
            pad_word = len[31:0];
        end
    end

    // Select what gets written into the buffer this cycle.
    always_comb begin
        wr_data = bus.i_data;
        if (state == PAD) begin
            wr_data = pad_word;
        end else if (bus.i_last && (bus.i_nbytes < 3'd4)) begin
            wr_data = marked_word;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FILL: begin
                if (take) begin
                    if (idx == 4'd15) begin
                        state_nxt = EMIT;
                    end else if (bus.i_last) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            PAD: begin
                if (idx == 4'd15) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (bus.i_blk_ready) begin
                    if (len_placed) begin
                        state_nxt = IDLE;
                    end else if (msg_done) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer, word index, bit length and message flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                blk_buf[i] <= '0;
            end
            idx        <= '0;
            len        <= '0;
            in_msg     <= 1'b0;
            msg_done   <= 1'b0;
            mark_done  <= 1'b0;
            first_pend <= 1'b0;
            len_ok     <= 1'b0;
            hi_done    <= 1'b0;
            len_placed <= 1'b0;
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (take) begin
                        blk_buf[idx] <= wr_data;
                        idx          <= idx + 4'd1;
                        len          <= (in_msg ? len : '0) + len_add;
                        if (!in_msg) begin
                            in_msg     <= 1'b1;
                            first_pend <= 1'b1;
                        end
                        if (bus.i_last) begin
                            msg_done <= 1'b1;
                            if (bus.i_nbytes < 3'd4) begin
                                mark_done <= 1'b1;
                                len_ok    <= (idx <= 4'd13);
                            end
                        end
                    end
                end
                PAD: begin
                    blk_buf[idx] <= wr_data;
                    idx          <= idx + 4'd1;
                    if (!mark_done) begin
                        mark_done <= 1'b1;
                        len_ok    <= (idx <= 4'd13);
                    end else if ((idx == 4'd14) && len_ok) begin
                        hi_done <= 1'b1;
                    end else if ((idx == 4'd15) && hi_done) begin
                        len_placed <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.i_blk_ready) begin
                        for (int i = 0; i < WORDS; i++) begin
                            blk_buf[i] <= '0;
                        end
                        idx        <= '0;
                        first_pend <= 1'b0;
                        if (len_placed) begin
                            in_msg     <= 1'b0;
                            msg_done   <= 1'b0;
                            mark_done  <= 1'b0;
                            len_ok     <= 1'b0;
                            hi_done    <= 1'b0;
                            len_placed <= 1'b0;
                        end else begin
                            // A marker placed in an earlier block frees words 14/15 here.
                            len_ok <= mark_done;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready     = (state == IDLE) || (state == FILL);
    assign bus.o_blk_valid = (state == EMIT);
    assign bus.o_blk_first = (state == EMIT) && first_pend;
    assign bus.o_blk_last  = (state == EMIT) && len_placed;
    assign fsm_state       = state;

    // Word 0 occupies the top of the block.
    for (genvar g = 0; g < WORDS; g++) begin : g_blk
        assign bus.o_blk[MSG_SIZ-1-g*MSG_BLK -: MSG_BLK] = blk_buf[g];
    end
endmodule

// File: doc/sha_msg_padder.md
# sha_msg_padder

Front-end message formatter for the SHA-256 hashing path. It accepts a message as a stream of 32-bit big-endian words, applies FIPS 180-4 padding (a 0x80 marker, zero fill, and the 64-bit bit length), and presents complete 512-bit blocks with a valid/ready handshake. Its block output drives the `i_msg` input of the SHA datapath. First-block and last-block flags tell the control unit when to load the IV and when the final hash is valid.

## Interface
- `MSG_SIZ`, 512: block width in bits.
- `MSG_BLK`, 32: input word width in bits.
- `LEN_W`, 64: message bit-length counter width.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `i_valid` input 1: input word valid.
- `o_ready` output 1: word accepted when `i_valid && o_ready`.
- `i_data` input `MSG_BLK`: message word. First byte in [31:24].
- `i_nbytes` input 3: count of valid bytes in `i_data`, 0..4, left-justified. Value 0 is legal only with `i_last`.
- `i_last` input 1: marks the final word of the message.
- `o_blk` output `MSG_SIZ`: block. Word 0 in [511:480].
- `o_blk_valid` output 1: block available.
- `i_blk_ready` input 1: block consumed when `o_blk_valid && i_blk_ready`.
- `o_blk_first` output 1: the current block is the first block of its message.
- `o_blk_last` output 1: the current block is the final padded block.

## Operation
- **Storage.** 16×32 block buffer, 4-bit word index `idx`, `LEN_W` bit counter `len`.
  - Flags: `in_msg` (a message is open), `msg_done` (last word taken), `mark_done` (0x80 written), `first_pend` (next emitted block is the first).
- **States.**
  - IDLE: `o_ready`=1.
  - FILL: `o_ready`=1.
  - PAD: `o_ready`=0.
  - EMIT: `o_ready`=0, `o_blk_valid`=1.
- **IDLE/FILL word accept.**
  - Store `i_data` at `idx` and add `i_nbytes*8` to `len`. `len` wraps modulo 2^64.
  - The first accept after IDLE clears `len` before the add and sets `first_pend`.
  - Not `i_last`: `idx`++. If `idx` was 15, go to EMIT; otherwise stay in FILL.
  - `i_last` with `i_nbytes` < 4:
    - Stored word = data bytes, then 0x80 at byte position `i_nbytes`, then zeros.
    - Set `mark_done` and `msg_done`, then `idx`++.
    - Next state: EMIT if `idx` was 15, else PAD.
  - `i_last` with `i_nbytes` = 4: store data and set `msg_done` (`mark_done` stays 0).
    - Next state: EMIT if `idx` was 15, else PAD with `idx`++.
  - `i_nbytes` = 0 without `i_last`: word accepted, nothing stored, `idx` and `len` unchanged.
- **PAD.** Writes one word per cycle at `idx`, then `idx`++:
  - `!mark_done`: write 0x80000000 and set `mark_done`.
  - Else if `idx` = 14 and the marker lies at word ≤ 13 of this block, or in an earlier block: write `len[63:32]`.
  - Else if `idx` = 15 and the length-high word was written: write `len[31:0]` and set `len_placed`.
  - Else: write 0.
  - After the write at `idx` = 15, go to EMIT.
- **EMIT.**
  - `o_blk_first` = `first_pend`.
  - `o_blk_last` = `len_placed`.
  - `o_blk` and both flags are held stable until the handshake.
- **On handshake.**
  - Zero the buffer, set `idx`=0, clear `first_pend`.
  - If `len_placed`: clear all flags and go to IDLE.
  - Else if `msg_done`: go to PAD (extra block).
  - Else: go to FILL.
- **Reset.** Clears all state and drops any partial block and any message in flight.
- **Reset values.**
  - `o_ready`=1.
  - `o_blk_valid`=0, `o_blk_first`=0, `o_blk_last`=0.
  - `o_blk`=0.

## Timing
- FILL throughput is one word per cycle. A full 16-word block that is not last reaches EMIT the cycle after the 16th accept.
- Final block, last word accepted at cycle T at index k < 15:
  - PAD runs 15−k cycles.
  - `o_blk_valid` rises at T+1+(15−k).
- EMIT lasts at least 1 cycle. With `i_blk_ready` held high, the next FILL accept can happen the cycle after the handshake.
- An extra padding block is needed when the marker lands at word ≥ 14, or when a full last word sits at index ≥ 14. It costs 16 PAD cycles plus EMIT.
- No combinational path from `i_blk_ready` to `o_ready`. `o_ready` is a registered state decode.
- `i_valid` during PAD or EMIT is ignored; the word is not consumed.

## Test plan
- **"abc".** Input 0x61626300, nbytes 3, last.
  - Expected block: word0=0x61626380, words 1..14=0, word15=0x00000018.
  - Flags: first=1, last=1.
- **Empty message.** Input nbytes 0, last.
  - Expected block: word0=0x80000000, rest 0.
  - Flags: first=1, last=1.
- **56 bytes.** 14 full words 0x00010203..., last on word 13.
  - Block 1: data in words 0..13, word14=0x80000000, word15=0, first=1, last=0.
  - Block 2: all zero except word15=0x000001C0, first=0, last=1.
- **64 bytes.** 16 full words.
  - Block 1: the data, last=0.
  - Block 2: word0=0x80000000, word15=0x00000200.
- **Backpressure.** Hold `i_blk_ready` low 5 cycles during EMIT.
  - `o_blk` and the flags stay unchanged; `o_ready` stays 0.
  - Block accepted on the first cycle `i_blk_ready` is high.
- **Reset mid-fill.** Assert `reset` after 7 words, then send "abc".
  - Output block is identical to the "abc" case, with first=1.
